// File: rtl/unified_memory.sv
// Flop-based shared instruction/data store: DEPTH x 32-bit words, read-only fetch
// port, read/write load-store port, write-first forwarding. Optional macro: MEM_BOUNDS_CHECK_EN.
module unified_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read1_sig,
    input  logic [31:0] read1_address,
    output logic [31:0] read1_out,
    input  logic        read2_sig,
    input  logic [31:0] read2_address,
    output logic [31:0] read2_out,
    input  logic        write2_sig,
    input  logic [31:0] write2_address,
    input  logic [31:0] write2_value
);

    // No handshake: enables and addresses are sampled on every rising edge,
    // so a new access may be issued each cycle with one-cycle read latency.

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] read1_index;
    logic [ADDR_W-1:0] read2_index;
    logic [ADDR_W-1:0] write2_index;

    logic              read1_ok;
    logic              read2_ok;
    logic              write2_ok;

    logic              write_en;
    logic              read1_fwd;
    logic              read2_fwd;
    logic [31:0]       read1_next;
    logic [31:0]       read2_next;

    assign read1_index  = read1_address[ADDR_W-1:0];
    assign read2_index  = read2_address[ADDR_W-1:0];
    assign write2_index = write2_address[ADDR_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    // Any address bit at or above ADDR_W marks the access out of range.
    assign read1_ok  = (read1_address[31:ADDR_W] == '0);
    assign read2_ok  = (read2_address[31:ADDR_W] == '0);
    assign write2_ok = (write2_address[31:ADDR_W] == '0);
`else
    // Upper address bits are ignored so addresses wrap modulo DEPTH.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{read1_address[31:ADDR_W],
                                 read2_address[31:ADDR_W],
                                 write2_address[31:ADDR_W]};
    assign read1_ok  = 1'b1;
    assign read2_ok  = 1'b1;
    assign write2_ok = 1'b1;
`endif

    assign write_en = write2_sig && write2_ok;

    // Forward only a write that will actually land in memory this edge.
    assign read1_fwd = write_en && read1_ok && (read1_index == write2_index);
    assign read2_fwd = write_en && read2_ok && (read2_index == write2_index);

    always_comb begin
        read1_next = '0;
        if (read1_ok) begin
            read1_next = read1_fwd ? write2_value : mem[read1_index];
        end
    end

    always_comb begin
        read2_next = '0;
        if (read2_ok) begin
            read2_next = read2_fwd ? write2_value : mem[read2_index];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[write2_index] <= write2_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read1_out <= '0;
            read2_out <= '0;
        end else begin
            if (read1_sig) begin
                read1_out <= read1_next;
            end
            if (read2_sig) begin
                read2_out <= read2_next;
            end
        end
    end

endmodule

// File: tb/tb_unified_memory.sv
// Directed bench for unified_memory: reset, write/read, write-first, enable hold,
// back-to-back traffic, wrap/bounds and mid-cycle reset.
module tb_unified_memory;

    logic        clk;
    logic        reset;
    logic        read1_sig;
    logic [31:0] read1_address;
    logic [31:0] read1_out;
    logic        read2_sig;
    logic [31:0] read2_address;
    logic [31:0] read2_out;
    logic        write2_sig;
    logic [31:0] write2_address;
    logic [31:0] write2_value;

    int errors;
    int checks;
    logic [31:0] exp_q[$];

    unified_memory #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .read1_sig      (read1_sig),
        .read1_address  (read1_address),
        .read1_out      (read1_out),
        .read2_sig      (read2_sig),
        .read2_address  (read2_address),
        .read2_out      (read2_out),
        .write2_sig     (write2_sig),
        .write2_address (write2_address),
        .write2_value   (write2_value)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks: inputs change #1 after a rising edge, outputs sampled there too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read1_sig      = 1'b0;
        read2_sig      = 1'b0;
        write2_sig     = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] value);
        write2_sig     = 1'b1;
        write2_address = addr;
        write2_value   = value;
    endtask

    task automatic drive_read1(input logic [31:0] addr);
        read1_sig     = 1'b1;
        read1_address = addr;
    endtask

    task automatic drive_read2(input logic [31:0] addr);
        read2_sig     = 1'b1;
        read2_address = addr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        read1_address  = '0;
        read2_address  = '0;
        write2_address = '0;
        write2_value   = '0;
        #1;
        checks++;
        if (read1_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_r1 got=%h exp=%h", read1_out, 32'h0);
        end
        checks++;
        if (read2_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_r2 got=%h exp=%h", read2_out, 32'h0);
        end
        cycle();
        reset = 1'b0;
        drive_read1(32'd0);
        drive_read2(32'd2);
        cycle();
        checks++;
        if (read1_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem0 got=%h exp=%h", read1_out, 32'h0);
        end
        checks++;
        if (read2_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem2 got=%h exp=%h", read2_out, 32'h0);
        end
        drive_read1(32'd3);
        drive_read2(32'd3);
        cycle();
        checks++;
        if (read1_out !== 32'h0 || read2_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem3 got=%h/%h exp=0/0", read1_out, read2_out);
        end
        idle();
    endtask

    task automatic test_write_read();
        drive_write(32'd0, 32'd666);
        cycle();
        idle();
        drive_read1(32'd0);
        drive_read2(32'd3);
        cycle();
        checks++;
        if (read1_out !== 32'd666) begin
            errors++;
            $display("FAIL write_read_r1 got=%0d exp=%0d", read1_out, 666);
        end
        checks++;
        if (read2_out !== 32'd0) begin
            errors++;
            $display("FAIL write_read_r2 got=%0d exp=%0d", read2_out, 0);
        end
        idle();
    endtask

    task automatic test_write_first();
        drive_write(32'd2, 32'h1234_5678);
        drive_read1(32'd2);
        drive_read2(32'd2);
        cycle();
        checks++;
        if (read1_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_first_r1 got=%h exp=%h", read1_out, 32'h1234_5678);
        end
        checks++;
        if (read2_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_first_r2 got=%h exp=%h", read2_out, 32'h1234_5678);
        end
        idle();
    endtask

    task automatic test_enable_hold();
        drive_read2(32'd0);
        cycle();
        checks++;
        if (read2_out !== 32'd666) begin
            errors++;
            $display("FAIL hold_load got=%0d exp=%0d", read2_out, 666);
        end
        read2_sig     = 1'b0;
        read2_address = 32'd3;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (read2_out !== 32'd666) begin
                errors++;
                $display("FAIL hold_r2_%0d got=%0d exp=%0d", i, read2_out, 666);
            end
        end
        read1_address = 32'd3;
        cycle();
        checks++;
        if (read1_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL hold_r1 got=%h exp=%h", read1_out, 32'h1234_5678);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        drive_write(32'd10, 32'h0000_0100);
        cycle();
        drive_write(32'd11, 32'h0000_0201);
        cycle();
        drive_write(32'd12, 32'h0000_0302);
        cycle();
        drive_write(32'd13, 32'h0000_0403);
        cycle();
        idle();
        // port 1 ascends while port 2 descends
        exp_q.push_back(32'h0000_0100); exp_q.push_back(32'h0000_0403);
        exp_q.push_back(32'h0000_0201); exp_q.push_back(32'h0000_0302);
        exp_q.push_back(32'h0000_0302); exp_q.push_back(32'h0000_0201);
        exp_q.push_back(32'h0000_0403); exp_q.push_back(32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            drive_read1(32'd10 + i);
            drive_read2(32'd13 - i);
            cycle();
            exp = exp_q.pop_front();
            checks++;
            if (read1_out !== exp) begin
                errors++;
                $display("FAIL b2b_r1_%0d got=%h exp=%h", i, read1_out, exp);
            end
            exp = exp_q.pop_front();
            checks++;
            if (read2_out !== exp) begin
                errors++;
                $display("FAIL b2b_r2_%0d got=%h exp=%h", i, read2_out, exp);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp3;
        logic [31:0] exp4;
`ifdef MEM_BOUNDS_CHECK_EN
        exp1 = 32'd666;
        exp2 = 32'h0;
        exp3 = 32'h0;
        exp4 = 32'h0;
`else
        exp1 = 32'hAA;
        exp2 = 32'hAA;
        exp3 = 32'h55;
        exp4 = 32'h55;
`endif
        drive_write(32'd256, 32'hAA);
        cycle();
        idle();
        drive_read1(32'd0);
        drive_read2(32'd256);
        cycle();
        checks++;
        if (read1_out !== exp1) begin
            errors++;
            $display("FAIL wrap_r1_addr0 got=%h exp=%h", read1_out, exp1);
        end
        checks++;
        if (read2_out !== exp2) begin
            errors++;
            $display("FAIL wrap_r2_addr256 got=%h exp=%h", read2_out, exp2);
        end
        drive_write(32'd261, 32'h55);
        drive_read1(32'd5);
        drive_read2(32'd261);
        cycle();
        checks++;
        if (read1_out !== exp3) begin
            errors++;
            $display("FAIL wrap_fwd_r1 got=%h exp=%h", read1_out, exp3);
        end
        checks++;
        if (read2_out !== exp4) begin
            errors++;
            $display("FAIL wrap_fwd_r2 got=%h exp=%h", read2_out, exp4);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        drive_write(32'd0, 32'd666);
        cycle();
        idle();
        drive_read1(32'd0);
        drive_read2(32'd0);
        cycle();
        checks++;
        if (read1_out !== 32'd666 || read2_out !== 32'd666) begin
            errors++;
            $display("FAIL mid_preload got=%0d/%0d exp=666/666", read1_out, read2_out);
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (read1_out !== 32'h0 || read2_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_async_clear got=%h/%h exp=0/0", read1_out, read2_out);
        end
        #1;
        reset = 1'b0;
        drive_read1(32'd0);
        drive_read2(32'd2);
        cycle();
        checks++;
        if (read1_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_mem0 got=%h exp=%h", read1_out, 32'h0);
        end
        checks++;
        if (read2_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_mem2 got=%h exp=%h", read2_out, 32'h0);
        end
        idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_write_first();
        test_enable_hold();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
